// File: rtl/hall_sensor_decoder_if.sv
// Hall decoder signal bundle: raw sensor input plus every decoded output.
// The decoder connects through the slave modport; the sensor/monitor side uses master.
interface hall_sensor_decoder_if #(
  parameter int PERIOD_W = 24
);
  logic [2:0]          iHALL;
  logic [2:0]          oHALL;
  logic [2:0]          oSECTOR;
  logic                oFAULT;
  logic                oSTEP;
  logic                oDIR;
  logic                oSKIP;
  logic [PERIOD_W-1:0] oPERIOD;
  logic                oPERIOD_VALID;
  logic                oSTALL;
  logic signed [31:0]  oPOSITION;

  modport master (
    output iHALL,
    input  oHALL, oSECTOR, oFAULT, oSTEP, oDIR, oSKIP,
    input  oPERIOD, oPERIOD_VALID, oSTALL, oPOSITION
  );

  modport slave (
    input  iHALL,
    output oHALL, oSECTOR, oFAULT, oSTEP, oDIR, oSKIP,
    output oPERIOD, oPERIOD_VALID, oSTALL, oPOSITION
  );
endinterface

// File: rtl/hall_sensor_decoder.sv
// Hall sensor decoder: synchronizes and debounces the 3-bit hall code, decodes the
// sector, classifies transitions into steps/skips, tracks position, and measures
// the step period with a stall timeout.
module hall_sensor_decoder #(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT    = 2400000,
  parameter int PERIOD_W   = 24
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  hall_sensor_decoder_if.slave bus
);

  localparam logic [7:0]          FLT_PRE = 8'(FILTER_LEN - 2);
  localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    P_UNARMED,
    P_ARMED,
    P_STALLED
  } pstate_t;

  logic [2:0]          s1_q, s2_q, s2_prev_q;
  logic [2:0]          hall_q, prev_sec_q;
  logic [7:0]          flt_cnt_q;
  logic                step_q, skip_q, dir_q, pval_q;
  logic [PERIOD_W-1:0] per_cnt_q, period_q;
  logic signed [31:0]  pos_q;
  pstate_t             pst_q, pst_d;

  logic [2:0]          new_sec;
  logic                flt_clear, load, both_ok;
  logic                fwd_step, rev_step, step_ev, skip_ev;
  logic [PERIOD_W-1:0] per_inc;
  logic                timeout_hit, measure;

  function automatic logic [2:0] sector_of(input logic [2:0] h);
    case (h)
      3'b101:  sector_of = 3'd0;
      3'b100:  sector_of = 3'd1;
      3'b110:  sector_of = 3'd2;
      3'b010:  sector_of = 3'd3;
      3'b011:  sector_of = 3'd4;
      3'b001:  sector_of = 3'd5;
      default: sector_of = 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] sec_next(input logic [2:0] s);
    sec_next = (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sec_prev(input logic [2:0] s);
    sec_prev = (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  // Filter decision, transition classification and period-counter arithmetic
  always_comb begin
    new_sec     = sector_of(s2_q);
    flt_clear   = (s2_q != s2_prev_q) || (s2_q == hall_q);
    load        = !flt_clear && (flt_cnt_q == FLT_PRE);
    both_ok     = (new_sec != 3'd7) && (prev_sec_q != 3'd7);
    fwd_step    = load && both_ok && (new_sec == sec_next(prev_sec_q));
    rev_step    = load && both_ok && (new_sec == sec_prev(prev_sec_q));
    skip_ev     = load && both_ok && !fwd_step && !rev_step;
    step_ev     = fwd_step || rev_step;
    per_inc     = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
    timeout_hit = !step_ev && (per_inc == TO_LAST);
  end

  // Period-measurement state: a step arms it, a timeout stalls it
  always_comb begin
    pst_d   = pst_q;
    measure = 1'b0;
    unique case (pst_q)
      P_UNARMED: begin
        if (step_ev)          pst_d = P_ARMED;
        else if (timeout_hit) pst_d = P_STALLED;
      end
      P_ARMED: begin
        if (step_ev)          measure = 1'b1;
        else if (timeout_hit) pst_d = P_STALLED;
      end
      P_STALLED: begin
        if (step_ev)          pst_d = P_ARMED;
      end
      default: pst_d = P_UNARMED;
    endcase
  end

  // Two-flop synchronizer plus last-cycle copy; it keeps sampling through reset so
  // the filtered code and previous sector load the live sensor value at release
  always_ff @(posedge iCLK) begin
    s1_q      <= bus.iHALL;
    s2_q      <= s1_q;
    s2_prev_q <= s2_q;
  end

  // Stability counter and filtered hall code / previous sector
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      hall_q     <= s2_q;
      prev_sec_q <= new_sec;
      flt_cnt_q  <= '0;
    end else begin
      if (flt_clear) flt_cnt_q <= '0;
      else           flt_cnt_q <= flt_cnt_q + 8'd1;
      if (load) begin
        hall_q     <= s2_q;
        prev_sec_q <= new_sec;
      end
    end
  end

  // Step/skip pulses, direction, position and period measurement
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      step_q    <= 1'b0;
      skip_q    <= 1'b0;
      dir_q     <= 1'b1;
      pos_q     <= '0;
      per_cnt_q <= '0;
      period_q  <= '0;
      pval_q    <= 1'b0;
    end else begin
      step_q <= step_ev;
      skip_q <= skip_ev;
      if (step_ev) begin
        dir_q     <= fwd_step;
        pos_q     <= fwd_step ? pos_q + 32'sd1 : pos_q - 32'sd1;
        per_cnt_q <= '0;
      end else begin
        per_cnt_q <= per_inc;
      end
      if (measure) begin
        period_q <= per_inc;
        pval_q   <= 1'b1;
      end else if (timeout_hit) begin
        pval_q   <= 1'b0;
      end
    end
  end

  // Period-measurement state register
  always_ff @(posedge iCLK) begin
    if (!iRESETn) pst_q <= P_UNARMED;
    else          pst_q <= pst_d;
  end

  assign bus.oHALL         = hall_q;
  assign bus.oSECTOR       = sector_of(hall_q);
  assign bus.oFAULT        = (hall_q == 3'b000) || (hall_q == 3'b111);
  assign bus.oSTEP         = step_q;
  assign bus.oDIR          = dir_q;
  assign bus.oSKIP         = skip_q;
  assign bus.oPERIOD       = period_q;
  assign bus.oPERIOD_VALID = pval_q;
  assign bus.oSTALL        = (pst_q == P_STALLED);
  assign bus.oPOSITION     = pos_q;

endmodule

// File: tb/tb_hall_sensor_decoder.sv
// Testbench for hall_sensor_decoder: directed sequences, a vector table and
// random stimulus, all checked every cycle against a behavioural model.
module tb_hall_sensor_decoder;
  localparam int F    = 16;
  localparam int TO   = 5000;
  localparam int PW   = 24;
  localparam int PMAX = (1 << PW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   n           = 0;
  bit   check_en    = 1'b0;

  hall_sensor_decoder_if #(.PERIOD_W(PW)) bus ();

  hall_sensor_decoder #(.FILTER_LEN(F), .TIMEOUT(TO), .PERIOD_W(PW)) dut (
    .iCLK    (clk),
    .iRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         sec_tbl   [8] = '{7, 5, 3, 4, 1, 0, 2, 7};
  logic [2:0] fwd_codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  // behavioural model state
  logic [2:0]         raw_q [$];
  logic [2:0]         m_hall = 3'b101;
  logic               m_step = 1'b0, m_skip = 1'b0, m_dir = 1'b1;
  logic               m_pval = 1'b0, m_stall = 1'b0, m_armed = 1'b0;
  int                 m_ref = 0;
  logic [PW-1:0]      m_period = '0;
  logic signed [31:0] m_pos = '0;

  typedef struct {
    logic [2:0] code;
    int         cyc;
    logic [2:0] hall;
    int         sector;
    logic       fault;
    int         steps;
    int         skips;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Model: a code is accepted once the synchronized input has shown it for F
  // consecutive samples; the step is judged by sector distance mod 6, the period
  // by elapsed cycles since the last step or reset.
  task automatic model_edge(input logic [2:0] h, input logic rn);
    logic [2:0] v;
    bit         stable, fwd, rev;
    int         ns, ps, d, el;
    raw_q.push_back(h);
    if (raw_q.size() > 40) raw_q.delete(0);
    v      = raw_q[raw_q.size() - 3];
    m_step = 1'b0;
    m_skip = 1'b0;
    if (!rn) begin
      m_hall = v; m_ref = n; m_armed = 1'b0; m_stall = 1'b0;
      m_pval = 1'b0; m_period = '0; m_pos = '0; m_dir = 1'b1;
    end else begin
      stable = 1'b1;
      for (int k = 0; k < F; k++)
        if (raw_q[raw_q.size() - 3 - k] != v) stable = 1'b0;
      fwd = 1'b0;
      rev = 1'b0;
      if (stable && v != m_hall) begin
        ns = sec_tbl[v];
        ps = sec_tbl[m_hall];
        m_hall = v;
        if (ns != 7 && ps != 7) begin
          d = (ns - ps + 6) % 6;
          fwd = (d == 1);
          rev = (d == 5);
          m_skip = !(fwd || rev);
        end
      end
      if (fwd || rev) begin
        m_step = 1'b1;
        m_dir  = fwd;
        m_pos  = fwd ? m_pos + 1 : m_pos - 1;
        if (m_armed && !m_stall) begin
          el = n - m_ref;
          m_period = (el > PMAX) ? PW'(PMAX) : PW'(el);
          m_pval = 1'b1;
        end
        m_armed = 1'b1;
        m_stall = 1'b0;
        m_ref   = n;
      end else if (n - m_ref == TO - 1) begin
        m_stall = 1'b1;
        m_pval  = 1'b0;
        m_armed = 1'b0;
      end
    end
  endtask

  task automatic cmp_model();
    logic [67:0] act, exp;
    act = {bus.oHALL, bus.oSECTOR, bus.oFAULT, bus.oSTEP, bus.oDIR, bus.oSKIP,
           bus.oPERIOD, bus.oPERIOD_VALID, bus.oSTALL, bus.oPOSITION};
    exp = {m_hall, 3'(sec_tbl[m_hall]), (m_hall == 3'b000 || m_hall == 3'b111),
           m_step, m_dir, m_skip, m_period, m_pval, m_stall, m_pos};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model cycle %0d: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic tick(input logic [2:0] h, input logic rn);
    bus.iHALL = h;
    rst_n     = rn;
    @(posedge clk);
    n++;
    model_edge(h, rn);
    #1;
    if (check_en) cmp_model();
  endtask

  task automatic hold(input logic [2:0] h, input int cyc, output int steps, output int skips);
    steps = 0;
    skips = 0;
    for (int i = 0; i < cyc; i++) begin
      tick(h, 1'b1);
      steps += int'(bus.oSTEP);
      skips += int'(bus.oSKIP);
    end
  endtask

  initial begin
    int st, sk, st2, sk2, lat, seen, cur, nxt, r;
    for (int i = 0; i < 20; i++) raw_q.push_back(3'b101);

    // reset state
    for (int i = 0; i < 4; i++) tick(3'b101, 1'b0);
    check("rst_hall", bus.oHALL, 5);
    check("rst_sector", bus.oSECTOR, 0);
    check("rst_fault", bus.oFAULT, 0);
    check("rst_step", bus.oSTEP, 0);
    check("rst_skip", bus.oSKIP, 0);
    check("rst_dir", bus.oDIR, 1);
    check("rst_pos", bus.oPOSITION, 0);
    check("rst_period", bus.oPERIOD, 0);
    check("rst_pval", bus.oPERIOD_VALID, 0);
    check("rst_stall", bus.oSTALL, 0);
    check_en = 1'b1;
    hold(3'b101, 5, st, sk);

    // filter latency and first forward step
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(3'b100, 1'b1);
      if (lat == 0 && bus.oHALL == 3'b100) begin
        lat = i;
        check("lat_step", bus.oSTEP, 1);
        check("lat_dir", bus.oDIR, 1);
        check("lat_pos", bus.oPOSITION, 1);
      end
    end
    check("latency", lat, F + 2);

    // glitch rejection: 15 cycles rejected, 16 accepted
    hold(3'b101, 30, st, sk);
    hold(3'b100, 15, st, sk);
    hold(3'b101, 30, st2, sk2);
    check("glitch15_steps", st + st2, 0);
    check("glitch15_hall", bus.oHALL, 5);
    hold(3'b100, 16, st, sk);
    hold(3'b101, 40, st2, sk2);
    check("glitch16_steps", st + st2, 2);
    check("glitch16_pos", bus.oPOSITION, 0);

    // reset in the middle of filtering
    hold(3'b100, 10, st, sk);
    for (int i = 0; i < 5; i++) tick(3'b100, 1'b0);
    hold(3'b100, 30, st, sk);
    check("rstmid_steps", st, 0);
    check("rstmid_hall", bus.oHALL, 4);
    check("rstmid_pos", bus.oPOSITION, 0);

    // period: first step only arms, second measures 1000
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(3'b110, 1'b1);
      if (bus.oSTEP) begin seen++; check("per_first_pval", bus.oPERIOD_VALID, 0); end
    end
    for (int i = 0; i < 1000; i++) begin
      tick(3'b010, 1'b1);
      if (bus.oSTEP) begin
        seen++;
        check("per_value", bus.oPERIOD, 1000);
        check("per_pval", bus.oPERIOD_VALID, 1);
      end
    end
    check("per_steps", seen, 2);

    // 12 forward then 3 reverse steps from a fresh reset
    for (int i = 0; i < 5; i++) tick(3'b010, 1'b0);
    hold(3'b010, 5, st, sk);
    check("dir_pos0", bus.oPOSITION, 0);
    seen = 0;
    cur  = 3;
    for (int k = 0; k < 15; k++) begin
      cur = (k < 12) ? (cur + 1) % 6 : (cur + 5) % 6;
      hold(fwd_codes[cur], 20, st, sk);
      seen += st;
    end
    check("dir_steps", seen, 15);
    check("dir_pos", bus.oPOSITION, 9);
    check("dir_dir", bus.oDIR, 0);
    check("dir_hall", bus.oHALL, 5);

    // stall after TIMEOUT idle cycles, cleared by the next step
    hold(3'b101, TO, st, sk);
    check("stall_set", bus.oSTALL, 1);
    check("stall_pval", bus.oPERIOD_VALID, 0);
    check("stall_period_held", bus.oPERIOD, 20);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(3'b100, 1'b1);
      if (bus.oSTEP) begin
        seen++;
        check("stall_clear", bus.oSTALL, 0);
        check("stall_step_pval", bus.oPERIOD_VALID, 0);
        check("stall_step_pos", bus.oPOSITION, 10);
      end
    end
    check("stall_steps", seen, 1);

    // skip and fault handling
    hold(3'b101, 20, st, sk);
    hold(3'b110, 20, st, sk);
    check("skip_count", sk, 1);
    check("skip_nostep", st, 0);
    check("skip_pos", bus.oPOSITION, 9);
    hold(3'b100, 20, st, sk);
    hold(3'b111, 20, st, sk);
    check("fault_pulses", st + sk, 0);
    check("fault_flag", bus.oFAULT, 1);
    check("fault_sector", bus.oSECTOR, 7);
    hold(3'b101, 20, st, sk);
    check("fault_exit_pulses", st + sk, 0);

    // vector table
    tbl.push_back(vec_t'{3'b100, 20, 3'b100, 1, 1'b0, 1, 0});
    tbl.push_back(vec_t'{3'b110, 20, 3'b110, 2, 1'b0, 1, 0});
    tbl.push_back(vec_t'{3'b100, 20, 3'b100, 1, 1'b0, 1, 0});
    tbl.push_back(vec_t'{3'b011, 20, 3'b011, 4, 1'b0, 0, 1});
    tbl.push_back(vec_t'{3'b000, 20, 3'b000, 7, 1'b1, 0, 0});
    tbl.push_back(vec_t'{3'b001, 20, 3'b001, 5, 1'b0, 0, 0});
    tbl.push_back(vec_t'{3'b101, 20, 3'b101, 0, 1'b0, 1, 0});
    tbl.push_back(vec_t'{3'b001, 20, 3'b001, 5, 1'b0, 1, 0});
    tbl.push_back(vec_t'{3'b001,  5, 3'b001, 5, 1'b0, 0, 0});
    tbl.push_back(vec_t'{3'b111, 10, 3'b001, 5, 1'b0, 0, 0});
    tbl.push_back(vec_t'{3'b010, 20, 3'b010, 3, 1'b0, 0, 1});
    foreach (tbl[i]) begin
      hold(tbl[i].code, tbl[i].cyc, st, sk);
      check($sformatf("tbl%0d_hall", i), bus.oHALL, tbl[i].hall);
      check($sformatf("tbl%0d_sector", i), bus.oSECTOR, tbl[i].sector);
      check($sformatf("tbl%0d_fault", i), bus.oFAULT, tbl[i].fault);
      check($sformatf("tbl%0d_steps", i), st, tbl[i].steps);
      check($sformatf("tbl%0d_skips", i), sk, tbl[i].skips);
    end

    // random rotation with glitches, skips, faults and occasional resets
    nxt = 3'b010;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(99);
      if (r < 3) begin
        for (int i = 0; i < int'($urandom_range(4, 1)); i++) tick(3'(nxt), 1'b0);
      end else begin
        cur = sec_tbl[nxt];
        if (r < 75 && cur != 7)
          nxt = fwd_codes[($urandom_range(1) != 0) ? (cur + 1) % 6 : (cur + 5) % 6];
        else if (r < 75)
          nxt = fwd_codes[$urandom_range(5)];
        else
          nxt = $urandom_range(7);
        hold(3'(nxt), $urandom_range(35, 1), st, sk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
